// File: rtl/risc_v_decode_stage.sv
// risc_v_decode_stage: registered RV32I decoder with a one-entry valid/ready output register.
// Illegal encodings decode to a side-effect-free ADD with illegal_o set.
module risc_v_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [4:0]  alu_op_o,
    output logic [1:0]  src_a_sel_o,
    output logic        src_b_imm_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        illegal_o,
    output logic [31:0] pc_o
);
    localparam logic [4:0] OP = 5'b01100, OP_IMM = 5'b00100, LUI = 5'b01101, AUIPC = 5'b00101;
    localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000, BRANCH = 5'b11000;
    localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, SYSTEM = 5'b11100, MISC_MEM = 5'b00011;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [1:0]  src_a_sel;
        logic        src_b_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
        logic [31:0] pc;
    } dec_t;

    dec_t        dec, dec_d, dec_q;
    logic        valid_d, valid_q, legal, accept;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // ALU codes follow the miriscv layout: {0, funct7[5], funct3} for arithmetic, {11, funct3} for branches
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (instr_i[6:2])
            OP: begin
                legal      = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                dec.alu_op = {1'b0, f7[5], f3};
                dec.rd_we  = 1'b1;
            end
            OP_IMM: begin
                legal         = f3 == 3'b001 ? f7 == 7'h00 :
                                f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                dec.alu_op    = {1'b0, f3 == 3'b101 && f7[5], f3};
                dec.src_b_imm = 1'b1;
                dec.imm       = imm_i;
                dec.rd_we     = 1'b1;
            end
            LUI, AUIPC: begin
                dec.src_a_sel = instr_i[5] ? 2'd2 : 2'd1;
                dec.src_b_imm = 1'b1;
                dec.imm       = imm_u;
                dec.rd_we     = 1'b1;
            end
            LOAD: begin
                legal         = f3 != 3'b011 && f3[2:1] != 2'b11;
                dec.src_b_imm = 1'b1;
                dec.imm       = imm_i;
                dec.mem_req   = 1'b1;
                dec.mem_size  = f3;
                dec.rd_we     = 1'b1;
            end
            STORE: begin
                legal         = f3 < 3'b011;
                dec.src_b_imm = 1'b1;
                dec.imm       = imm_s;
                dec.mem_req   = 1'b1;
                dec.mem_we    = 1'b1;
                dec.mem_size  = f3;
            end
            BRANCH: begin
                legal      = f3[2:1] != 2'b01;
                dec.alu_op = {2'b11, f3};
                dec.branch = 1'b1;
                dec.imm    = imm_b;
            end
            JAL: begin
                dec.src_a_sel = 2'd1;
                dec.src_b_imm = 1'b1;
                dec.imm       = imm_j;
                dec.jal       = 1'b1;
                dec.rd_we     = 1'b1;
            end
            JALR: begin
                legal         = f3 == 3'b000;
                dec.src_b_imm = 1'b1;
                dec.imm       = imm_i;
                dec.jalr      = 1'b1;
                dec.rd_we     = 1'b1;
            end
            SYSTEM, MISC_MEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        if (!legal || instr_i[1:0] != 2'b11) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.rd_we = dec.rd_we && instr_i[11:7] != 5'd0;
        dec.rs1   = instr_i[19:15];
        dec.rs2   = instr_i[24:20];
        dec.rd    = instr_i[11:7];
        dec.pc    = pc_i;
    end

    assign instr_ready_o = !valid_q || dec_ready_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    always_comb begin
        valid_d = flush_i ? 1'b0 : accept ? 1'b1 : valid_q && !dec_ready_i;
        dec_d   = accept ? dec : dec_q;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign dec_valid_o = valid_q;
    assign alu_op_o    = dec_q.alu_op;
    assign src_a_sel_o = dec_q.src_a_sel;
    assign src_b_imm_o = dec_q.src_b_imm;
    assign imm_o       = dec_q.imm;
    assign rs1_addr_o  = dec_q.rs1;
    assign rs2_addr_o  = dec_q.rs2;
    assign rd_addr_o   = dec_q.rd;
    assign rd_we_o     = dec_q.rd_we;
    assign mem_req_o   = dec_q.mem_req;
    assign mem_we_o    = dec_q.mem_we;
    assign mem_size_o  = dec_q.mem_size;
    assign branch_o    = dec_q.branch;
    assign jal_o       = dec_q.jal;
    assign jalr_o      = dec_q.jalr;
    assign illegal_o   = dec_q.illegal;
    assign pc_o        = valid_q ? dec_q.pc : RESET_PC;
endmodule

// File: tb/tb_risc_v_decode_stage.sv
// tb_risc_v_decode_stage: random and directed stimulus against an opcode-table reference model,
// with expected entries queued at accept and popped by an independent output monitor.
module tb_risc_v_decode_stage;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd8, SLL = 5'd1, SLT = 5'd2, SLTU = 5'd3, XOR = 5'd4;
    localparam logic [4:0] SRL = 5'd5, SRA = 5'd13, OR = 5'd6, AND = 5'd7;
    localparam logic [4:0] BEQ = 5'd24, BNE = 5'd25, BLT = 5'd28, BGE = 5'd29, BLTU = 5'd30, BGEU = 5'd31;

    logic        clk_i = 1'b0, arstn_i = 1'b0, flush_i = 1'b0, instr_valid_i = 1'b0, dec_ready_i = 1'b0;
    logic [31:0] instr_i = '0, pc_i = '0;
    logic        instr_ready_o, dec_valid_o, src_b_imm_o, rd_we_o, mem_req_o, mem_we_o;
    logic        branch_o, jal_o, jalr_o, illegal_o;
    logic [4:0]  alu_op_o, rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [1:0]  src_a_sel_o;
    logic [2:0]  mem_size_o;
    logic [31:0] imm_o, pc_o;

    risc_v_decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush_i), .instr_i(instr_i), .pc_i(pc_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .dec_valid_o(dec_valid_o),
        .dec_ready_i(dec_ready_i), .alu_op_o(alu_op_o), .src_a_sel_o(src_a_sel_o),
        .src_b_imm_o(src_b_imm_o), .imm_o(imm_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_size_o(mem_size_o), .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
        .illegal_o(illegal_o), .pc_o(pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  alu;
        logic [1:0]  sa;
        logic        sb;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        we, req, mwe;
        logic [2:0]  size;
        logic        br, jal, jalr, ill;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [4:0]  rop[8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        logic [4:0]  bop[8] = '{BEQ, BNE, ADD, ADD, BLT, BGE, BLTU, BGEU};
        logic [31:0] ii, si, bi, ui, ji;
        int          op, f3, f7;
        bit          bad = 0;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        ii = $signed(ins) >>> 20;
        si = (ii & ~32'd31) | ((ins >> 7) & 32'd31);
        bi = (si & ~32'h801) | (((ins >> 7) & 32'd1) << 11);
        ui = ins & 32'hFFFF_F000;
        ji = (ii & 32'hFFF0_07FE) | (ins & 32'h000F_F000) | (((ins >> 20) & 32'd1) << 11);
        e = '{alu: ADD, sa: 0, sb: 0, imm: 0, rs1: ins[19:15], rs2: ins[24:20], rd: ins[11:7],
              we: 0, req: 0, mwe: 0, size: 0, br: 0, jal: 0, jalr: 0, ill: 0, pc: pc};
        case (op)
            'h33: begin
                e.we = 1;
                if (f7 == 0) e.alu = rop[f3];
                else if (f7 == 'h20 && f3 == 0) e.alu = SUB;
                else if (f7 == 'h20 && f3 == 5) e.alu = SRA;
                else bad = 1;
            end
            'h13: begin
                e.we = 1; e.sb = 1; e.imm = ii; e.alu = rop[f3];
                if (f3 == 1 && f7 != 0) bad = 1;
                if (f3 == 5 && f7 == 'h20) e.alu = SRA;
                else if (f3 == 5 && f7 != 0) bad = 1;
            end
            'h37: begin e.we = 1; e.sa = 2; e.sb = 1; e.imm = ui; end
            'h17: begin e.we = 1; e.sa = 1; e.sb = 1; e.imm = ui; end
            'h03: begin
                e.we = 1; e.sb = 1; e.imm = ii; e.req = 1; e.size = ins[14:12];
                bad = f3 == 3 || f3 == 6 || f3 == 7;
            end
            'h23: begin
                e.sb = 1; e.imm = si; e.req = 1; e.mwe = 1; e.size = ins[14:12];
                bad = f3 >= 3;
            end
            'h63: begin e.br = 1; e.imm = bi; e.alu = bop[f3]; bad = f3 == 2 || f3 == 3; end
            'h6F: begin e.we = 1; e.jal = 1; e.sa = 1; e.sb = 1; e.imm = ji; end
            'h67: begin e.we = 1; e.jalr = 1; e.sb = 1; e.imm = ii; bad = f3 != 0; end
            'h73, 'h0F: ;
            default: bad = 1;
        endcase
        if (bad) e = '{alu: ADD, sa: 0, sb: 0, imm: 0, rs1: ins[19:15], rs2: ins[24:20], rd: ins[11:7],
                       we: 0, req: 0, mwe: 0, size: 0, br: 0, jal: 0, jalr: 0, ill: 1, pc: pc};
        if (e.rd == 0) e.we = 0;
        return e;
    endfunction

    // Output monitor: every presented entry must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (arstn_i && dec_valid_o && !flush_i) begin
            if (q.size() == 0) chk("unexpected_entry_pc", pc_o, 32'hxxxx_xxxx);
            else begin
                chk("alu_op", alu_op_o, q[0].alu);
                chk("src_a_sel", src_a_sel_o, q[0].sa);
                chk("src_b_imm", src_b_imm_o, q[0].sb);
                chk("imm", imm_o, q[0].imm);
                chk("rs1", rs1_addr_o, q[0].rs1);
                chk("rs2", rs2_addr_o, q[0].rs2);
                chk("rd", rd_addr_o, q[0].rd);
                chk("rd_we", rd_we_o, q[0].we);
                chk("mem_req", mem_req_o, q[0].req);
                chk("mem_we", mem_we_o, q[0].mwe);
                chk("mem_size", mem_size_o, q[0].size);
                chk("branch", branch_o, q[0].br);
                chk("jal", jal_o, q[0].jal);
                chk("jalr", jalr_o, q[0].jalr);
                chk("illegal", illegal_o, q[0].ill);
                chk("pc", pc_o, q[0].pc);
                if (dec_ready_i) void'(q.pop_front());
            end
        end
    end

    task automatic post(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy, input logic fl);
        logic held;
        held = q.size() != 0;
        chk("dec_valid", dec_valid_o, held);
        chk("instr_ready", instr_ready_o, !held || rdy);
        if (fl) q.delete();
        else if (v && (!held || rdy)) q.push_back(model(ins, pc));
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy, input logic fl);
        @(posedge clk_i);
        #1;
        instr_valid_i = v; instr_i = ins; pc_i = pc; dec_ready_i = fl ? 1'b0 : rdy; flush_i = fl;
        #3;
        post(v, ins, pc, fl ? 1'b0 : rdy, fl);
    endtask

    task automatic rst_chk();
        chk("rst_dec_valid", dec_valid_o, 0);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_instr_ready", instr_ready_o, 1);
        chk("rst_alu_op", alu_op_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_rd_we", rd_we_o, 0);
        chk("rst_illegal", illegal_o, 0);
    endtask

    task automatic reset_release(input logic [31:0] ins, input logic [31:0] pc);
        instr_valid_i = 1; instr_i = ins; pc_i = pc; dec_ready_i = 1; flush_i = 0;
        repeat (2) begin
            @(negedge clk_i);
            rst_chk();
        end
        @(posedge clk_i);
        #1;
        arstn_i = 1;
        #3;
        post(1, ins, pc, 1, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73, 7'h0F};
        logic [31:0] ins;
        int          k, r;
        ins = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) ins[6:0] = ops[k];
        r = $urandom_range(0, 3);
        if (r == 0) ins[31:25] = 7'h00;
        if (r == 1) ins[31:25] = 7'h20;
        return ins;
    endfunction

    initial begin
        reset_release(32'h40B5_0533, 32'h100);
        step(1, 32'hFFF5_8593, 32'h104, 1, 0);
        repeat (3) step(1, 32'hFE05_48E3, 32'h108, 0, 0);
        step(1, 32'hFE05_48E3, 32'h108, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(1, 32'h00A0_0093, 32'h10C, 1, 1);
        step(0, 32'h0, 32'h0, 1, 0);
        step(1, 32'h0000_0000, 32'h110, 1, 0);
        step(1, 32'h02B5_0533, 32'h114, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk_i);
                #2;
                arstn_i = 0;
                q.delete();
                reset_release(rand_instr(), $urandom);
            end
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end
        repeat (3) step(0, 32'h0, 32'h0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
